pipeline_hazard_ctrl: RTL and testbench

// - Hazard controller for the 5-stage pipelined CPU. Drives the clear/stall controls of the F/D and D/E pipeline registers and the E-stage operand forwarding muxes.
// - Resolves three hazard classes: load-use, taken branch and PC (R15) write.
// - The FSM sequences multi-cycle flush and stall windows. Forwarding is combinational.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the hazard controller (slave).
// The datapath drives the stage register/control information; the controller returns stall, flush and forward selects.
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] RA1D;
  logic [ADDR_W-1:0] RA2D;
  logic [ADDR_W-1:0] RA1E;
  logic [ADDR_W-1:0] RA2E;
  logic [ADDR_W-1:0] WA3E;
  logic [ADDR_W-1:0] WA3M;
  logic [ADDR_W-1:0] WA3W;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemToRegE;
  logic              PCSrcD;
  logic              PCSrcW;
  logic              BranchTakenE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        StateO;
  logic [PERF_W-1:0] StallCnt;
  logic [PERF_W-1:0] FlushCnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE,
    output PCSrcD, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  StateO, StallCnt, FlushCnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE,
    input  PCSrcD, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output StateO, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, taken-branch flush window, PC-write wait, E-stage forwarding.
// Optional saturating stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    BR_FLUSH = 2'b01,
    PC_WAIT  = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_REG    = ADDR_W'(32'd15);
  localparam logic [2:0]        FLUSH_LD  = 3'(FLUSH_CYCLES);
  localparam bit                HAS_FLUSH = (FLUSH_CYCLES != 0);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       lduse_s;
  logic       stall_f_s;
  logic       stall_d_s;
  logic       flush_d_s;
  logic       flush_e_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // R15 reads come from the PC path, so they are never forwarded; M beats W.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] ra,
    input logic              wr_m,
    input logic [ADDR_W-1:0] wa_m,
    input logic              wr_w,
    input logic [ADDR_W-1:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra == PC_REG) begin
      sel = 2'b00;
    end else if (wr_m && (wa_m == ra)) begin
      sel = 2'b10;
    end else if (wr_w && (wa_w == ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand forwarding selects, forced to the register file while in reset.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (RST) begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end else begin
      fwd_a_s = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      fwd_b_s = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
    end
  end

  // Load in E whose destination is read by the instruction in D.
  always_comb begin
    lduse_s = 1'b0;
    if (hz.MemToRegE && hz.RegWriteE &&
        ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D))) begin
      lduse_s = 1'b1;
    end else begin
      lduse_s = 1'b0;
    end
  end

  // Mealy stall/flush decode and next-state selection; branch > PC write > load-use.
  always_comb begin
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (RST) begin
      flush_d_s   = 1'b1;
      flush_e_s   = 1'b1;
      state_nxt_s = RUN;
      cnt_nxt_s   = 3'd0;
    end else if (hz.BranchTakenE) begin
      // Taken branch overrides every window, including a PC-write wait.
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
      if (HAS_FLUSH) begin
        state_nxt_s = BR_FLUSH;
        cnt_nxt_s   = FLUSH_LD;
      end else begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 3'd0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (hz.PCSrcD) begin
            stall_f_s   = 1'b1;
            flush_d_s   = 1'b1;
            state_nxt_s = PC_WAIT;
          end else if (lduse_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        BR_FLUSH: begin
          flush_d_s = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            cnt_nxt_s = cnt_r - 3'd1;
          end
        end
        PC_WAIT: begin
          stall_f_s = 1'b1;
          flush_d_s = 1'b1;
          if (hz.PCSrcW) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PC_WAIT;
          end
        end
        default: begin
          flush_d_s   = 1'b1;
          flush_e_s   = 1'b1;
          state_nxt_s = RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  // Window state and flush down-counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] stall_cnt_r;
  logic [PERF_W-1:0] flush_cnt_r;

  // Saturating event counters for StallF and FlushE cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_r <= {PERF_W{1'b0}};
      flush_cnt_r <= {PERF_W{1'b0}};
    end else begin
      if (stall_f_s && (stall_cnt_r != PERF_MAX)) begin
        stall_cnt_r <= stall_cnt_r + PERF_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_e_s && (flush_cnt_r != PERF_MAX)) begin
        flush_cnt_r <= flush_cnt_r + PERF_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.StallCnt = stall_cnt_r;
  assign hz.FlushCnt = flush_cnt_r;
`else
  assign hz.StallCnt = {PERF_W{1'b0}};
  assign hz.FlushCnt = {PERF_W{1'b0}};
`endif

  assign hz.ForwardAE = fwd_a_s;
  assign hz.ForwardBE = fwd_b_s;
  assign hz.StallF    = stall_f_s;
  assign hz.StallD    = stall_d_s;
  assign hz.FlushD    = flush_d_s;
  assign hz.FlushE    = flush_e_s;
  assign hz.StateO    = state_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: main instance (FLUSH_CYCLES=2, PERF_W=16) plus a
// FLUSH_CYCLES=0 / PERF_W=4 instance fed the same inputs for the zero-window and saturation cases.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_hazard_ctrl_if #(.ADDR_W(4), .PERF_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.ADDR_W(4), .PERF_W(4))  bus_s ();

  pipeline_hazard_ctrl #(.ADDR_W(4), .FLUSH_CYCLES(2), .PERF_W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .hz  (bus)
  );

  pipeline_hazard_ctrl #(.ADDR_W(4), .FLUSH_CYCLES(0), .PERF_W(4)) dut_s (
    .CLK (clk),
    .RST (rst),
    .hz  (bus_s)
  );

  assign bus_s.RA1D         = bus.RA1D;
  assign bus_s.RA2D         = bus.RA2D;
  assign bus_s.RA1E         = bus.RA1E;
  assign bus_s.RA2E         = bus.RA2E;
  assign bus_s.WA3E         = bus.WA3E;
  assign bus_s.WA3M         = bus.WA3M;
  assign bus_s.WA3W         = bus.WA3W;
  assign bus_s.RegWriteE    = bus.RegWriteE;
  assign bus_s.RegWriteM    = bus.RegWriteM;
  assign bus_s.RegWriteW    = bus.RegWriteW;
  assign bus_s.MemToRegE    = bus.MemToRegE;
  assign bus_s.PCSrcD       = bus.PCSrcD;
  assign bus_s.PCSrcW       = bus.PCSrcW;
  assign bus_s.BranchTakenE = bus.BranchTakenE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RA1D = 4'd0; bus.RA2D = 4'd0; bus.RA1E = 4'd0; bus.RA2E = 4'd0;
    bus.WA3E = 4'd0; bus.WA3M = 4'd0; bus.WA3W = 4'd0;
    bus.RegWriteE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.MemToRegE = 1'b0; bus.PCSrcD = 1'b0; bus.PCSrcW = 1'b0;
    bus.BranchTakenE = 1'b0;
  endtask

  task automatic set_lduse(input logic [3:0] ra1d, input logic [3:0] ra2d, input logic we);
    bus.MemToRegE = 1'b1; bus.RegWriteE = we; bus.WA3E = 4'd5;
    bus.RA1D = ra1d; bus.RA2D = ra2d;
  endtask

  task automatic check_ctl(input string tag, input logic sf, input logic sd,
                           input logic fd, input logic fe, input logic [1:0] st);
    check_val({tag, ".StallF"}, {31'd0, bus.StallF}, {31'd0, sf});
    check_val({tag, ".StallD"}, {31'd0, bus.StallD}, {31'd0, sd});
    check_val({tag, ".FlushD"}, {31'd0, bus.FlushD}, {31'd0, fd});
    check_val({tag, ".FlushE"}, {31'd0, bus.FlushE}, {31'd0, fe});
    check_val({tag, ".StateO"}, {30'd0, bus.StateO}, {30'd0, st});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b1;
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd3; bus.RA1E = 4'd3;
    tick();
    tick();
    // Reset state, forwarding held at regfile while in reset.
    check_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    check_val("rst.fwdA", {30'd0, bus.ForwardAE}, 32'd0);
    check_val("rst.stallcnt", {16'd0, bus.StallCnt}, 32'd0);
    check_val("rst.flushcnt", {16'd0, bus.FlushCnt}, 32'd0);
    rst = 1'b0;
    idle_inputs();
    #1;
    check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Forwarding
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd3; bus.RegWriteW = 1'b1; bus.WA3W = 4'd3;
    bus.RA1E = 4'd3; bus.RA2E = 4'd3;
    #1;
    check_val("fwd.m_over_w.A", {30'd0, bus.ForwardAE}, 32'd2);
    check_val("fwd.m_over_w.B", {30'd0, bus.ForwardBE}, 32'd2);
    bus.RegWriteM = 1'b0;
    #1;
    check_val("fwd.w.A", {30'd0, bus.ForwardAE}, 32'd1);
    bus.RA1E = 4'd15; bus.WA3M = 4'd15; bus.RegWriteM = 1'b1; bus.WA3W = 4'd15;
    bus.RA2E = 4'd4;
    #1;
    check_val("fwd.r15.A", {30'd0, bus.ForwardAE}, 32'd0);
    check_val("fwd.nomatch.B", {30'd0, bus.ForwardBE}, 32'd0);
    bus.WA3W = 4'd4;
    #1;
    check_val("fwd.w.B", {30'd0, bus.ForwardBE}, 32'd1);
    idle_inputs();

    // Load-use: no stall without RegWriteE, then RA2D and RA1D matches
    set_lduse(4'd0, 4'd5, 1'b0);
    #1;
    check_val("lduse.nowe", {31'd0, bus.StallF}, 32'd0);
    set_lduse(4'd0, 4'd5, 1'b1);
    #1;
    check_ctl("lduse.ra2", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    idle_inputs();
    #1;
    check_ctl("lduse.after", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_val("lduse.stallcnt", {16'd0, bus.StallCnt}, pc(1));
    check_val("lduse.flushcnt", {16'd0, bus.FlushCnt}, pc(1));
    set_lduse(4'd5, 4'd0, 1'b1);
    #1;
    check_ctl("lduse.ra1", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    idle_inputs();
    #1;
    check_val("lduse2.stallcnt", {16'd0, bus.StallCnt}, pc(2));

    // Branch with simultaneous PCSrcD; load-use during the window is ignored
    bus.BranchTakenE = 1'b1; bus.PCSrcD = 1'b1;
    #1;
    check_ctl("br.c0", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    idle_inputs();
    set_lduse(4'd0, 4'd5, 1'b1);
    #1;
    check_ctl("br.c1", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    check_val("br0.c1.state", {30'd0, bus_s.StateO}, 32'd0);
    check_val("br0.c1.stallF", {31'd0, bus_s.StallF}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check_ctl("br.c2", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    check_ctl("br.c3", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_val("br.flushcnt", {16'd0, bus.FlushCnt}, pc(3));
    check_val("br.stallcnt", {16'd0, bus.StallCnt}, pc(2));

    // Branch re-trigger inside the window reloads the counter
    bus.BranchTakenE = 1'b1;
    tick();
    #1;
    check_ctl("rebr.c1", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    bus.BranchTakenE = 1'b0;
    tick();
    check_ctl("rebr.c3", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    check_ctl("rebr.c4", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // PC write: wait until PCSrcW
    bus.PCSrcD = 1'b1;
    #1;
    check_ctl("pc.c0", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    bus.PCSrcD = 1'b0;
    #1;
    check_ctl("pc.c1", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
    tick();
    tick();
    bus.PCSrcW = 1'b1;
    #1;
    check_ctl("pc.c3", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
    tick();
    bus.PCSrcW = 1'b0;
    #1;
    check_ctl("pc.c4", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // PC write aborted by a branch at c2
    bus.PCSrcD = 1'b1;
    tick();
    bus.PCSrcD = 1'b0;
    tick();
    bus.BranchTakenE = 1'b1;
    #1;
    check_ctl("pcbr.c2", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    tick();
    bus.BranchTakenE = 1'b0;
    #1;
    check_ctl("pcbr.c3", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    check_val("pcbr0.c3.state", {30'd0, bus_s.StateO}, 32'd0);
    tick();
    tick();
    check_val("pcbr.c5.state", {30'd0, bus.StateO}, 32'd0);
    check_val("end.stallcnt", {16'd0, bus.StallCnt}, pc(8));
    check_val("end.flushcnt", {16'd0, bus.FlushCnt}, pc(6));

    // Reset in the middle of a PC-write window
    bus.PCSrcD = 1'b1;
    tick();
    bus.PCSrcD = 1'b0;
    #1;
    check_val("midrst.pre", {30'd0, bus.StateO}, 32'd2);
    rst = 1'b1;
    #1;
    check_ctl("midrst", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    check_val("midrst.stallcnt", {16'd0, bus.StallCnt}, 32'd0);
    check_val("midrst.flushcnt", {16'd0, bus.FlushCnt}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_ctl("midrst.after", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Saturation: 20 load-use cycles
    set_lduse(4'd0, 4'd5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    idle_inputs();
    #1;
    check_val("sat.stallcnt4", {28'd0, bus_s.StallCnt}, pc(15));
    check_val("sat.flushcnt4", {28'd0, bus_s.FlushCnt}, pc(15));
    check_val("sat.stallcnt16", {16'd0, bus.StallCnt}, pc(20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
